// File: rtl/univ_shift_pkg.sv
// Shared mode encoding for the universal shift register
// and its per-bit cell.
package univ_shift_pkg;

  typedef logic [1:0] shift_mode_t;

  localparam shift_mode_t MODE_HOLD = 2'b00;
  localparam shift_mode_t MODE_SHL  = 2'b01;
  localparam shift_mode_t MODE_SHR  = 2'b10;
  localparam shift_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/univ_shift_reg_cell.sv
// One bit of the universal shift register:
// a 4:1 next-state mux in front of a posedge flop.
module shift_cell
  import univ_shift_pkg::*;
(
  input  logic        C,
  input  logic        R,
  input  logic        EN,
  input  shift_mode_t M,
  input  logic        LN,
  input  logic        RN,
  input  logic        PD,
  input  logic        RV,
  output logic        Q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (EN) begin
      unique case (M)
        MODE_SHL:  q_d = LN;
        MODE_SHR:  q_d = RN;
        MODE_LOAD: q_d = PD;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge C) begin
    if (R) q_q <= RV;
    else   q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift-left,
// shift-right, parallel load, optional rotate.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [63:0] RESET_VAL = 64'd0,
  parameter bit          ROTATE    = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  shift_mode_t      M,
  input  logic [WIDTH-1:0] D,
  input  logic             SL,
  input  logic             SR,
  output logic [WIDTH-1:0] Q,
  output logic             SOL,
  output logic             SOR,
  output logic             Z
);

  localparam logic [WIDTH-1:0] RV = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q;
  logic             lft_end;
  logic             rgt_end;

  // Chain ends either wrap around or take the serial pins
  assign lft_end = ROTATE ? q[WIDTH-1] : SL;
  assign rgt_end = ROTATE ? q[0] : SR;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ln;
    logic rn;
    if (i == 0) begin : g_lo
      assign ln = lft_end;
    end else begin : g_lo
      assign ln = q[i-1];
    end
    if (i == WIDTH - 1) begin : g_hi
      assign rn = rgt_end;
    end else begin : g_hi
      assign rn = q[i+1];
    end
    shift_cell u_cell (
      .C  (C),
      .R  (R),
      .EN (EN),
      .M  (M),
      .LN (ln),
      .RN (rn),
      .PD (D[i]),
      .RV (RV[i]),
      .Q  (q[i])
    );
  end

  assign Q   = q;
  assign SOL = q[WIDTH-1];
  assign SOR = q[0];
  assign Z   = (q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench: four configurations share one stimulus
// stream; a monitor checks every post-edge state.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  logic        C;
  logic        R;
  logic        EN;
  shift_mode_t M;
  logic [63:0] D;
  logic        SL;
  logic        SR;

  logic [7:0]  qa, qb;
  logic [1:0]  qc;
  logic [63:0] qd;
  logic [3:0]  sol, sor, z;

  localparam logic [63:0] RVA = 64'hA5;
  localparam logic [63:0] RVC = 64'h2;
  localparam logic [63:0] RVD = 64'h0123_4567_89AB_CDEF;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(RVA), .ROTATE(1'b0)) u_a (
    .C(C), .R(R), .EN(EN), .M(M), .D(D[7:0]), .SL(SL), .SR(SR),
    .Q(qa), .SOL(sol[0]), .SOR(sor[0]), .Z(z[0]));
  univ_shift_reg #(.WIDTH(8), .RESET_VAL(RVA), .ROTATE(1'b1)) u_b (
    .C(C), .R(R), .EN(EN), .M(M), .D(D[7:0]), .SL(SL), .SR(SR),
    .Q(qb), .SOL(sol[1]), .SOR(sor[1]), .Z(z[1]));
  univ_shift_reg #(.WIDTH(2), .RESET_VAL(RVC), .ROTATE(1'b0)) u_c (
    .C(C), .R(R), .EN(EN), .M(M), .D(D[1:0]), .SL(SL), .SR(SR),
    .Q(qc), .SOL(sol[2]), .SOR(sor[2]), .Z(z[2]));
  univ_shift_reg #(.WIDTH(64), .RESET_VAL(RVD), .ROTATE(1'b0)) u_d (
    .C(C), .R(R), .EN(EN), .M(M), .D(D), .SL(SL), .SR(SR),
    .Q(qd), .SOL(sol[3]), .SOR(sor[3]), .Z(z[3]));

  typedef struct {
    string       tag;
    logic [63:0] e0, e1, e2, e3;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_bad  = 0;
  logic [63:0] m0, m1, m2, m3;
  bit          stim_done = 0;

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  function automatic logic [63:0] nxt(
    logic [63:0] q, int w, bit rot, logic [63:0] rv,
    logic r, logic en, logic [1:0] m, logic [63:0] d,
    logic sl, logic sr);
    logic [63:0] mask;
    logic        b;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (r) return rv & mask;
    if (!en) return q;
    case (m)
      2'b01: begin
        b = rot ? q[w-1] : sl;
        return ((q << 1) | {63'd0, b}) & mask;
      end
      2'b10: begin
        b = rot ? q[0] : sr;
        return (q >> 1) | ({63'd0, b} << (w - 1));
      end
      2'b11:   return d & mask;
      default: return q;
    endcase
  endfunction

  task automatic chk(string tag, string dut, int w,
                     logic [63:0] act, logic [63:0] exp,
                     logic so_l, logic so_r, logic zz);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s Q: got %h want %h", tag, dut, act, exp);
    end
    n_vec++;
    if (so_l !== exp[w-1]) begin
      n_bad++;
      $display("FAIL %s/%s SOL: got %b want %b", tag, dut, so_l, exp[w-1]);
    end
    n_vec++;
    if (so_r !== exp[0]) begin
      n_bad++;
      $display("FAIL %s/%s SOR: got %b want %b", tag, dut, so_r, exp[0]);
    end
    n_vec++;
    if (zz !== (exp == 64'd0)) begin
      n_bad++;
      $display("FAIL %s/%s Z: got %b want %b", tag, dut, zz, exp == 64'd0);
    end
  endtask

  // Monitor: one expected entry per rising edge, checked 1ns later
  initial begin
    exp_t e;
    forever begin
      @(posedge C);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "w8", 8, {56'd0, qa}, e.e0, sol[0], sor[0], z[0]);
        chk(e.tag, "w8rot", 8, {56'd0, qb}, e.e1, sol[1], sor[1], z[1]);
        chk(e.tag, "w2", 2, {62'd0, qc}, e.e2, sol[2], sor[2], z[2]);
        chk(e.tag, "w64", 64, qd, e.e3, sol[3], sor[3], z[3]);
      end
    end
  end

  // ha/hb: hand-computed Q for the two 8-bit instances, -1 = model
  task automatic step(string tag, logic r, logic en, logic [1:0] m,
                      logic [63:0] d, logic sl, logic sr,
                      int ha, int hb);
    exp_t e;
    R = r; EN = en; M = m; D = d; SL = sl; SR = sr;
    @(posedge C);
    m0 = nxt(m0, 8, 1'b0, RVA, r, en, m, d, sl, sr);
    m1 = nxt(m1, 8, 1'b1, RVA, r, en, m, d, sl, sr);
    m2 = nxt(m2, 2, 1'b0, RVC, r, en, m, d, sl, sr);
    m3 = nxt(m3, 64, 1'b0, RVD, r, en, m, d, sl, sr);
    e.tag = tag;
    e.e0 = (ha >= 0) ? 64'(ha) : m0;
    e.e1 = (hb >= 0) ? 64'(hb) : m1;
    e.e2 = m2;
    e.e3 = m3;
    sb.push_back(e);
    @(negedge C);
  endtask

  initial begin
    logic [63:0] rd;
    int          la[8];
    int          rb[8];
    m0 = 'x; m1 = 'x; m2 = 'x; m3 = 'x;
    R = 0; EN = 0; M = MODE_HOLD; D = '0; SL = 0; SR = 0;
    @(negedge C);

    step("reset", 1, 1, MODE_LOAD, '1, 0, 0, 8'hA5, 8'hA5);

    step("load", 0, 1, MODE_LOAD, 64'hDEAD_BEEF_0000_003C, 0, 0, 8'h3C, 8'h3C);
    repeat (3) step("hold", 0, 1, MODE_HOLD, '1, 1, 1, 8'h3C, 8'h3C);
    repeat (3) step("en0", 0, 0, MODE_SHL, '1, 1, 1, 8'h3C, 8'h3C);

    step("ld81", 0, 1, MODE_LOAD, 64'h81, 0, 0, 8'h81, 8'h81);
    step("shl1", 0, 1, MODE_SHL, '0, 1, 0, 8'h03, 8'h03);
    step("shl2", 0, 1, MODE_SHL, '0, 1, 0, 8'h07, 8'h06);
    step("ld81", 0, 1, MODE_LOAD, 64'h81, 0, 0, 8'h81, 8'h81);
    step("shr", 0, 1, MODE_SHR, '0, 1, 0, 8'h40, 8'hC0);

    step("ld5a", 0, 1, MODE_LOAD, 64'h5A, 0, 0, 8'h5A, 8'h5A);
    la = '{8'hB4, 8'h68, 8'hD0, 8'hA0, 8'h40, 8'h80, 8'h00, 8'h00};
    rb = '{8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A};
    for (int i = 0; i < 8; i++)
      step("rot8", 0, 1, MODE_SHL, '0, 0, 0, la[i], rb[i]);

    step("ldff", 0, 1, MODE_LOAD, '1, 0, 0, 8'hFF, 8'hFF);
    la = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    for (int i = 0; i < 8; i++)
      step("zero", 0, 1, MODE_SHL, '0, 0, 0, la[i], 8'hFF);
    step("zero9", 0, 1, MODE_SHL, '0, 0, 0, 8'h00, 8'hFF);

    step("ldrnd", 0, 1, MODE_LOAD, 64'hFEDC_BA98_7654_3210, 0, 0, 8'h10, 8'h10);
    for (int i = 0; i < 40; i++) begin
      rd = {$urandom, $urandom};
      if (i == 5 || i == 23)
        step("midrst", 1, 1, (i[0] ? MODE_SHR : MODE_SHL), rd,
             1'($urandom), 1'($urandom), 8'hA5, 8'hA5);
      else if (i % 11 == 10)
        step("rndld", 0, 1, MODE_LOAD, rd, 0, 0, -1, -1);
      else
        step("rnd", 0, (i % 7 != 3), (i[0] ? MODE_SHR : MODE_SHL), rd,
             1'($urandom), 1'($urandom), -1, -1);
    end

    repeat (2) @(negedge C);
    stim_done = 1;
  end

  initial begin
    fork
      wait (stim_done);
      #100000;
    join_any
    disable fork;
    if (!stim_done || sb.size() != 0) begin
      n_bad++;
      $display("FAIL timeout: done=%0d pending=%0d want 1/0",
               stim_done, sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
